// File: rtl/rule_pkg.sv
// ---------------------------------------------------------------------------
// rule_pkg
// Shared constants and types for the rule-set intersection block.
//   NUM_RULE_ID    number of rule IDs a set can reference
//   RULE_ID_WIDTH  bits per rule ID
//   SET_WIDTH      bits per encoded rule-ID set
//   SLOT_WIDTH     bits per slot ({valid, id})
// ---------------------------------------------------------------------------
package rule_pkg;

   localparam int NUM_RULE_ID   = 8;
   localparam int RULE_ID_WIDTH = 3;
   localparam int SET_WIDTH     = 32;
   localparam int SLOT_WIDTH    = 4;
   localparam int NUM_SLOTS     = SET_WIDTH / SLOT_WIDTH;

   // One slot of an encoded set; valid is the leftmost bit of the nibble.
   typedef struct packed {
      logic                     valid;
      logic [RULE_ID_WIDTH-1:0] id;
   } slot_t;

endpackage

// File: rtl/rule_set_decode.sv
// ---------------------------------------------------------------------------
// rule_set_decode
// Combinational decode of one encoded rule-ID set into a one-hot-per-rule
// bitmap. Slot 0 occupies the leftmost nibble, slot 7 the rightmost.
// Optional well-formedness check built only when RULE_SET_CHECK_EN is
// defined.
//   set_in     encoded set, bits [0:31], slot s = bits [4s:4s+3]
//   bitmap     bit k set iff some valid slot holds id k
//   malformed  (RULE_SET_CHECK_EN only) set not right-justified or ids not
//              strictly ascending toward slot 7
// ---------------------------------------------------------------------------
module rule_set_decode
   import rule_pkg::*;
#(
   parameter int NUM_IDS = 8
) (
   input  logic [0:SET_WIDTH-1] set_in,
   output logic [NUM_IDS-1:0]   bitmap
`ifdef RULE_SET_CHECK_EN
   ,
   output logic                 malformed
`endif
);

   slot_t slots [NUM_SLOTS];

   // Ascending part-select keeps the leftmost bit of each nibble as MSB,
   // so it lands on slot_t.valid.
   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         assign slots[gi] = set_in[gi*SLOT_WIDTH +: SLOT_WIDTH];
      end
   endgenerate

   always_comb begin
      bitmap = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (slots[s].valid && (int'(slots[s].id) < NUM_IDS)) begin
            bitmap[slots[s].id] = 1'b1;
         end
      end
   end

`ifdef RULE_SET_CHECK_EN
   // A valid slot must be followed (toward slot 7) by another valid slot
   // with a strictly larger id.
   always_comb begin
      malformed = 1'b0;
      for (int s = 0; s < NUM_SLOTS - 1; s++) begin
         if (slots[s].valid && !slots[s+1].valid) begin
            malformed = 1'b1;
         end
         if (slots[s].valid && slots[s+1].valid && (slots[s].id >= slots[s+1].id)) begin
            malformed = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/rule_set_intersect.sv
// ---------------------------------------------------------------------------
// rule_set_intersect
// Pairs SIP and DIP rule-ID sets in arrival order, intersects their
// bitmaps and reports the lowest common rule ID.
//
// Pipeline: per-field FIFO (registered read) -> stage A (AND) -> output
// register. Sets accepted at edge t produce out_valid at edge t+3.
//
// Optional build macro: RULE_SET_CHECK_EN enables a sticky malformed-set
// flag on set_err; otherwise set_err is tied low.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   sip_valid/sip_set/sip_ready  SIP set input handshake
//   dip_valid/dip_set/dip_ready  DIP set input handshake
//   out_valid/out_ready          result handshake
//   out_match                    intersection non-empty
//   out_rule_id                  lowest common rule ID (0 if none)
//   out_bitmap                   intersection bitmap
//   set_err                      sticky malformed-set flag
// ---------------------------------------------------------------------------
module rule_set_intersect #(
   parameter int FIFO_DEPTH  = 4,
   parameter int NUM_RULE_ID = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               sip_valid,
   input  logic [0:rule_pkg::SET_WIDTH-1]     sip_set,
   output logic                               sip_ready,
   input  logic                               dip_valid,
   input  logic [0:rule_pkg::SET_WIDTH-1]     dip_set,
   output logic                               dip_ready,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               out_match,
   output logic [rule_pkg::RULE_ID_WIDTH-1:0] out_rule_id,
   output logic [NUM_RULE_ID-1:0]             out_bitmap,
   output logic                               set_err
);

   import rule_pkg::*;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Field 0 = SIP, field 1 = DIP.
   logic [0:SET_WIDTH-1]          field_set [2];
   logic [1:0]                    field_valid;
   logic [1:0]                    field_ready;
   logic [1:0]                    field_nonempty;
   logic [1:0][NUM_RULE_ID-1:0]   field_head;
`ifdef RULE_SET_CHECK_EN
   logic [1:0]                    field_malformed;
`endif

   logic                          pop;
   logic                          p_valid_reg;
   logic                          a_valid_reg;
   logic [NUM_RULE_ID-1:0]        a_bitmap_reg;
   logic                          out_valid_reg;
   logic                          out_match_reg;
   logic [RULE_ID_WIDTH-1:0]      out_rule_id_reg;
   logic [NUM_RULE_ID-1:0]        out_bitmap_reg;
   logic [RULE_ID_WIDTH-1:0]      low_id;
   logic                          o_adv;
   logic                          a_adv;
   logic                          p_adv;

   assign field_set[0] = sip_set;
   assign field_set[1] = dip_set;
   assign field_valid  = {dip_valid, sip_valid};
   assign sip_ready    = field_ready[0];
   assign dip_ready    = field_ready[1];

   // -----------------------------------------------------------------------
   // Per-field decode + FIFO. The FIFO read port is registered (head_reg),
   // which forms the first of the three pipeline stages.
   // -----------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_field
         logic [NUM_RULE_ID-1:0] bitmap;
         logic [NUM_RULE_ID-1:0] mem [FIFO_DEPTH];
         logic [PTR_W-1:0]       wr_ptr_reg;
         logic [PTR_W-1:0]       rd_ptr_reg;
         logic [CNT_W-1:0]       count_reg;
         logic [NUM_RULE_ID-1:0] head_reg;
         logic                   push;

         rule_set_decode #(
            .NUM_IDS (NUM_RULE_ID)
         ) u_decode (
            .set_in    (field_set[gi]),
            .bitmap    (bitmap)
`ifdef RULE_SET_CHECK_EN
            ,
            .malformed (field_malformed[gi])
`endif
         );

         assign field_ready[gi]    = (count_reg != CNT_W'(FIFO_DEPTH));
         assign field_nonempty[gi] = (count_reg != '0);
         assign push               = field_valid[gi] & field_ready[gi];
         assign field_head[gi]     = head_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push) begin
                  wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
               end
               if (pop) begin
                  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
               end
               if (push && !pop) begin
                  count_reg <= count_reg + CNT_W'(1);
               end else if (!push && pop) begin
                  count_reg <= count_reg - CNT_W'(1);
               end
            end
         end

         // Storage array without reset so it maps onto block RAM.
         always_ff @(posedge clk) begin
            if (push) begin
               mem[wr_ptr_reg] <= bitmap;
            end
            if (pop) begin
               head_reg <= mem[rd_ptr_reg];
            end
         end
      end
   endgenerate

   // -----------------------------------------------------------------------
   // Backpressure chain: each stage may take new data when it is empty or
   // its contents move on in the same cycle.
   // -----------------------------------------------------------------------
   assign o_adv = !out_valid_reg | out_ready;
   assign a_adv = !a_valid_reg | o_adv;
   assign p_adv = !p_valid_reg | a_adv;
   // Both fields pop together so sets stay paired by arrival order.
   assign pop   = (&field_nonempty) & p_adv;

   // Lowest set bit wins; scan from the top so the last hit is the lowest.
   always_comb begin
      low_id = '0;
      for (int k = NUM_RULE_ID - 1; k >= 0; k--) begin
         if (a_bitmap_reg[k]) begin
            low_id = RULE_ID_WIDTH'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_valid_reg     <= 1'b0;
         a_valid_reg     <= 1'b0;
         a_bitmap_reg    <= '0;
         out_valid_reg   <= 1'b0;
         out_match_reg   <= 1'b0;
         out_rule_id_reg <= '0;
         out_bitmap_reg  <= '0;
      end else begin
         if (p_adv) begin
            p_valid_reg <= pop;
         end
         if (a_adv) begin
            a_valid_reg  <= p_valid_reg;
            a_bitmap_reg <= field_head[0] & field_head[1];
         end
         if (o_adv) begin
            out_valid_reg <= a_valid_reg;
            if (a_valid_reg) begin
               out_bitmap_reg  <= a_bitmap_reg;
               out_match_reg   <= |a_bitmap_reg;
               out_rule_id_reg <= low_id;
            end
         end
      end
   end

   assign out_valid   = out_valid_reg;
   assign out_match   = out_match_reg;
   assign out_rule_id = out_rule_id_reg;
   assign out_bitmap  = out_bitmap_reg;

`ifdef RULE_SET_CHECK_EN
   logic set_err_reg;

   // Sticky: any accepted malformed set on either field latches the flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         set_err_reg <= 1'b0;
      end else if (|(field_valid & field_ready & field_malformed)) begin
         set_err_reg <= 1'b1;
      end
   end

   assign set_err = set_err_reg;
`else
   assign set_err = 1'b0;
`endif

endmodule

// File: tb/tb_rule_set_intersect.sv
// ---------------------------------------------------------------------------
// tb_rule_set_intersect
// Directed bench for rule_set_intersect: reset state, latency, empty
// intersection, one-sided buffering, output stall, malformed-set flag and
// mid-operation reset. Honours RULE_SET_CHECK_EN for set_err expectations.
// ---------------------------------------------------------------------------
module tb_rule_set_intersect;

   logic        clk;
   logic        reset;
   logic        sip_valid;
   logic [0:31] sip_set;
   logic        sip_ready;
   logic        dip_valid;
   logic [0:31] dip_set;
   logic        dip_ready;
   logic        out_valid;
   logic        out_ready;
   logic        out_match;
   logic [2:0]  out_rule_id;
   logic [7:0]  out_bitmap;
   logic        set_err;

   int checks = 0;
   int errors = 0;
   int rx_count = 0;

`ifdef RULE_SET_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   // Directed vectors; expected result = {match, rule_id, bitmap}.
   logic [31:0] sip_tbl [10];
   logic [31:0] dip_tbl [10];
   logic [11:0] exp_tbl [8];
   logic [11:0] exp_q [$];

   rule_set_intersect #(
      .FIFO_DEPTH  (4),
      .NUM_RULE_ID (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sip_valid   (sip_valid),
      .sip_set     (sip_set),
      .sip_ready   (sip_ready),
      .dip_valid   (dip_valid),
      .dip_set     (dip_set),
      .dip_ready   (dip_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_match   (out_match),
      .out_rule_id (out_rule_id),
      .out_bitmap  (out_bitmap),
      .set_err     (set_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams table entries into both inputs, each field with its own handshake.
   task automatic feed(input int s0, input int sn, input int d0, input int dn);
      int si = s0;
      int di = d0;
      int guard = 0;
      logic s_rdy;
      logic d_rdy;
      while (((si < s0 + sn) || (di < d0 + dn)) && (guard < 300)) begin
         sip_valid = (si < s0 + sn);
         sip_set   = sip_valid ? sip_tbl[si] : 32'h0;
         dip_valid = (di < d0 + dn);
         dip_set   = dip_valid ? dip_tbl[di] : 32'h0;
         s_rdy = sip_ready;
         d_rdy = dip_ready;
         tick();
         if (sip_valid && s_rdy) si++;
         if (dip_valid && d_rdy) di++;
         guard++;
      end
      sip_valid = 1'b0;
      dip_valid = 1'b0;
      check("feed_done", (guard < 300), 1);
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0) && (g < 100)) begin
         tick();
         g++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic expect_pair(input int i);
      exp_q.push_back(exp_tbl[i]);
   endtask

   // Result monitor: sampled at the falling edge, mid-cycle.
   logic       prev_stall = 1'b0;
   logic [7:0] held_bmp;
   logic       held_match;
   logic [2:0] held_id;

   always @(negedge clk) begin
      logic [11:0] e;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_bmp", out_bitmap, held_bmp);
            check("hold_match", out_match, held_match);
            check("hold_id", out_rule_id, held_id);
         end
         if (out_valid && out_ready) begin
            check("result_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("res_bmp", out_bitmap, e[7:0]);
               check("res_match", out_match, e[11]);
               check("res_id", out_rule_id, e[10:8]);
               rx_count++;
               $display("RESULT %0d bitmap=%02h match=%0d id=%0d", rx_count, out_bitmap, out_match, out_rule_id);
            end
         end
         prev_stall = out_valid && !out_ready;
         held_bmp   = out_bitmap;
         held_match = out_match;
         held_id    = out_rule_id;
      end
   end

   initial begin
      sip_tbl[0] = 32'h0009BDEF; dip_tbl[0] = 32'h0000CDEF; exp_tbl[0] = {1'b1, 3'd5, 8'hE0};
      sip_tbl[1] = 32'h00000000; dip_tbl[1] = 32'h0000000F; exp_tbl[1] = {1'b0, 3'd0, 8'h00};
      sip_tbl[2] = 32'h0000000F; dip_tbl[2] = 32'h0000000F; exp_tbl[2] = {1'b1, 3'd7, 8'h80};
      sip_tbl[3] = 32'h000000BF; dip_tbl[3] = 32'h000000AB; exp_tbl[3] = {1'b1, 3'd3, 8'h08};
      sip_tbl[4] = 32'h00089ABC; dip_tbl[4] = 32'h0000ACDE; exp_tbl[4] = {1'b1, 3'd2, 8'h14};
      sip_tbl[5] = 32'h0000009D; dip_tbl[5] = 32'h00009BDF; exp_tbl[5] = {1'b1, 3'd1, 8'h22};
      sip_tbl[6] = 32'h89ABCDEF; dip_tbl[6] = 32'h00000008; exp_tbl[6] = {1'b1, 3'd0, 8'h01};
      sip_tbl[7] = 32'h89ABCDEF; dip_tbl[7] = 32'h0000009B; exp_tbl[7] = {1'b1, 3'd1, 8'h0A};
      sip_tbl[8] = 32'h0000FFEF; dip_tbl[8] = 32'h00000000;
      sip_tbl[9] = 32'h0000000F; dip_tbl[9] = 32'h00000000;

      reset     = 1'b1;
      sip_valid = 1'b0;
      sip_set   = 32'h0;
      dip_valid = 1'b0;
      dip_set   = 32'h0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_sip_ready", sip_ready, 1);
      check("rst_dip_ready", dip_ready, 1);
      check("rst_out_match", out_match, 0);
      check("rst_out_id", out_rule_id, 0);
      check("rst_out_bmp", out_bitmap, 0);
      check("rst_set_err", set_err, 0);

      // Latency: accepted at edge t, out_valid at edge t+3
      expect_pair(0);
      sip_valid = 1'b1; sip_set = sip_tbl[0];
      dip_valid = 1'b1; dip_set = dip_tbl[0];
      tick();
      sip_valid = 1'b0; dip_valid = 1'b0;
      check("lat_t0", out_valid, 0);
      tick();
      check("lat_t1", out_valid, 0);
      tick();
      check("lat_t2", out_valid, 0);
      tick();
      check("lat_t3", out_valid, 1);
      drain();

      // Empty intersection
      expect_pair(1);
      feed(1, 1, 1, 1);
      drain();

      // One-sided buffering: SIP fills, then DIP releases in order
      feed(2, 4, 0, 0);
      check("sip_full_ready", sip_ready, 0);
      check("dip_idle_ready", dip_ready, 1);
      check("no_early_result", out_valid, 0);
      for (int i = 2; i < 6; i++) expect_pair(i);
      feed(0, 0, 2, 4);
      drain();
      check("sip_ready_back", sip_ready, 1);

      // Output stall for 10 cycles under continuous input
      for (int i = 0; i < 8; i++) expect_pair(i);
      out_ready = 1'b0;
      fork
         feed(0, 8, 0, 8);
         begin
            repeat (9) @(posedge clk);
            #1;
            check("stall_sip_ready", sip_ready, 0);
            check("stall_dip_ready", dip_ready, 0);
            check("stall_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("rx_after_stall", rx_count, 14);

      // Malformed set flag (sticky); set is still buffered
      check("err_before", set_err, 0);
      feed(8, 1, 0, 0);
      check("err_next_cycle", set_err, EXP_ERR);
      feed(9, 1, 0, 0);
      repeat (5) tick();
      check("err_sticky", set_err, EXP_ERR);
      check("orphan_no_result", out_valid, 0);

      // Reset with two SIP entries buffered
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_sip_ready", sip_ready, 1);
      check("mid_rst_dip_ready", dip_ready, 1);
      check("mid_rst_set_err", set_err, 0);
      expect_pair(3);
      feed(3, 1, 3, 1);
      drain();
      repeat (5) tick();
      check("rx_total", rx_count, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rule_set_intersect.md
RULE_SET_INTERSECT -- requirements
Module: rule_set_intersect

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, per-field input buffer depth in entries (power of 2, >=2).
REQ-002 SHALL have parameter NUM_RULE_ID, default 8, number of rule IDs in the rule set.
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- sip_valid  in  1  SIP rule ID set present
- sip_set  in  [0:31]  SIP rule ID set, 8 slots of {valid, id[2:0]}
- sip_ready  out  1  SIP buffer can accept
- dip_valid  in  1  DIP rule ID set present
- dip_set  in  [0:31]  DIP rule ID set, same format
- dip_ready  out  1  DIP buffer can accept
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_match  out  1  intersection non-empty
- out_rule_id  out  3  highest-priority (lowest) common rule ID
- out_bitmap  out  8  intersection bitmap, bit k = rule k
- set_err  out  1  sticky malformed-set flag

Function
REQ-004 Set format SHALL be: slot s = bits [4s:4s+3], bit 4s = valid; valid slots right-justified (slot 7 = LSB nibble), ids strictly ascending toward slot 7; all-zero = empty set.
REQ-005 Each set SHALL be decoded combinationally at input into an 8-bit bitmap (bit k set iff any valid slot holds id k); invalid slots ignored.
REQ-006 Per field, a FIFO of FIFO_DEPTH bitmaps SHALL be pushed on valid&ready; ready = !full, derived from registered occupancy count.
REQ-007 Push while full SHALL be impossible (ready low); simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-008 Both FIFOs SHALL pop in the same cycle iff both non-empty and stage A can advance; no single-sided pop.
REQ-009 Stage A SHALL register AND of the two popped bitmaps plus a valid bit; advances when empty or when output register empty/being accepted.
REQ-010 Output register SHALL load out_bitmap = stage-A bitmap, out_match = |bitmap, out_rule_id = index of lowest set bit (0 if none), out_valid = 1.
REQ-011 out_* SHALL hold stable while out_valid & !out_ready; cleared-valid on acceptance unless reloaded in the same cycle.
REQ-012 Latency SHALL be 3 cycles: both sets accepted at edge t -> out_valid at edge t+3 with out_ready high; throughput one result per cycle.
REQ-013 Results SHALL emerge in input order; sets pair strictly by arrival order per field.

Reset
REQ-014 Reset SHALL clear FIFO pointers/counts, stage-A valid, out_valid, out_match, out_rule_id, out_bitmap, set_err to 0; sip_ready/dip_ready read 1 in the first cycle after reset.
REQ-015 Reset mid-operation SHALL discard all buffered and in-flight sets; no result emitted for them.

Configuration
REQ-016 With RULE_SET_CHECK_EN defined, an accepted set that is not right-justified or not strictly ascending SHALL set set_err at the next edge, held until reset; set is still processed.
REQ-017 Without RULE_SET_CHECK_EN, set_err SHALL be tied 0 and no check logic built.

Structure
REQ-018 NUM_RULE_ID, RULE_ID_WIDTH (3), SET_WIDTH (32), slot width (4) SHALL live in shared package rule_pkg.
REQ-019 Decode (and optional check) SHALL be sub-module rule_set_decode, instantiated once per field; FIFO stays inline.

Verification
REQ-020 sip_set=0x0009BDEF, dip_set=0x0000CDEF same cycle -> 3 cycles later out_valid=1, out_bitmap=0xE0, out_match=1, out_rule_id=5.
REQ-021 sip_set=0x00000000, dip_set=0x0000000F -> out_match=0, out_rule_id=0, out_bitmap=0x00, out_valid=1.
REQ-022 4 SIP sets with dip_valid=0 -> sip_ready=0 after 4th; then 4 DIP sets -> 4 results in order, sip_ready returns 1.
REQ-023 out_ready=0 for 10 cycles under continuous input -> both readies drop, no result lost or duplicated, out_* stable.
REQ-024 With RULE_SET_CHECK_EN, sip_set=0x0000FFEF -> set_err=1 next cycle, stays 1 until reset; without macro stays 0.
REQ-025 Reset asserted with 2 entries buffered -> out_valid=0, readies=1, no stale result after release.
